serial_word_loader: RTL and testbench



---
 rtl/serial_loader_pkg.sv | 37 +++
 rtl/bit_counter_sat.sv | 48 ++++
 rtl/serial_word_loader.sv | 168 ++++++++++++++++
 tb/tb_serial_word_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_loader_pkg.sv
// serial_loader_pkg
// Shared definitions for the serial word loader and the pattern detector
// that consumes its parallel word.
//   state_e          : loader FSM states (IDLE, SHIFT, LOAD)
//   DEFAULT_WIDTH    : default number of data bits per frame
//   A_BIT .. H_BIT   : bit positions of detector inputs A..H on PAR_OUT
//   frame_bits()     : serial bits per frame, including the parity bit
//                      when SERIAL_PARITY_CHECK_EN is defined
package serial_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  localparam int A_BIT = 7;
  localparam int B_BIT = 6;
  localparam int C_BIT = 5;
  localparam int D_BIT = 4;
  localparam int E_BIT = 3;
  localparam int F_BIT = 2;
  localparam int G_BIT = 1;
  localparam int H_BIT = 0;

  // A parity-checked frame carries one trailing even-parity bit after the data.
  function automatic int frame_bits(input int width);
`ifdef SERIAL_PARITY_CHECK_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/bit_counter_sat.sv
// bit_counter_sat
// Saturating up-counter with synchronous clear and increment enable.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   clr    : clear count to zero (wins over inc)
//   inc    : increment by one; holds once MAX_COUNT is reached
//   count  : current count
//   tc     : terminal-count flag, high when the next increment reaches
//            MAX_COUNT (count == MAX_COUNT-1)
module bit_counter_sat #(
  parameter int MAX_COUNT = 8,
  localparam int CNT_W    = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_W'(MAX_COUNT))) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flag looks ahead one step so the FSM can decide on the accepting edge
  // without a combinational loop through inc.
  assign tc    = (count_q == CNT_W'(MAX_COUNT - 1));
  assign count = count_q;

endmodule

// File: rtl/serial_word_loader.sv
// serial_word_loader
// Assembles a START-framed, SVALID-qualified serial bit stream into a
// WIDTH-bit word and presents it on a registered bus that only changes
// when a complete word is loaded.
// Parameters:
//   WIDTH     : data bits per frame
//   MSB_FIRST : 1 = first bit lands in bit WIDTH-1 (A), 0 = first bit in bit 0
// Ports:
//   CLK        : clock, rising edge
//   RST_N      : synchronous active-low reset
//   START      : frame start pulse
//   SVALID     : SIN qualifier, one bit accepted per cycle while high
//   SIN        : serial data
//   PAR_OUT    : loaded word, bit WIDTH-1 = A ... bit 0 = H
//   WORD_VALID : one-cycle pulse when PAR_OUT takes a new word
//   BUSY       : high while a frame is being shifted in
//   FRAME_ERR  : one-cycle pulse on an aborted or parity-failed frame
// Build option:
//   SERIAL_PARITY_CHECK_EN : frames carry a trailing even-parity bit; a
//                            mismatch drops the word and pulses FRAME_ERR.
module serial_word_loader
  import serial_loader_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SVALID,
  input  logic             SIN,
  output logic [WIDTH-1:0] PAR_OUT,
  output logic             WORD_VALID,
  output logic             BUSY,
  output logic             FRAME_ERR
);

  localparam int FRAME_BITS = frame_bits(WIDTH);
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             word_valid_q, word_valid_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;

  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;
  logic [WIDTH-1:0] shift_in;

  bit_counter_sat #(
    .MAX_COUNT (FRAME_BITS)
  ) u_bit_counter (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt),
    .tc    (cnt_tc)
  );

  // Shift register contents after accepting SIN this cycle.
  always_comb begin
    if (MSB_FIRST != 0) begin
      shift_in = {shift_q[WIDTH-2:0], SIN};
    end else begin
      shift_in = {SIN, shift_q[WIDTH-1:1]};
    end
  end

  // Next-state logic. Outputs are computed one step ahead so that PAR_OUT,
  // WORD_VALID, BUSY and FRAME_ERR all come straight from flops.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    par_out_d    = par_out_q;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;

    case (state_q)
      IDLE: begin
        // START wins over SVALID; the bit in the START cycle is dropped.
        if (START) begin
          state_d = SHIFT;
          cnt_clr = 1'b1;
          shift_d = '0;
        end
      end

      SHIFT: begin
        if (START) begin
          // Restart inside a frame; only an error if bits were already taken.
          cnt_clr     = 1'b1;
          shift_d     = '0;
          frame_err_d = (cnt != '0);
        end else if (SVALID) begin
          cnt_inc = 1'b1;
`ifdef SERIAL_PARITY_CHECK_EN
          if (cnt_tc) begin
            // Final bit is even parity over the data already collected.
            state_d = LOAD;
            if ((^shift_q) == SIN) begin
              par_out_d    = shift_q;
              word_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            shift_d = shift_in;
          end
`else
          shift_d = shift_in;
          if (cnt_tc) begin
            state_d      = LOAD;
            par_out_d    = shift_in;
            word_valid_d = 1'b1;
          end
`endif
        end
      end

      LOAD: begin
        if (START) begin
          state_d = SHIFT;
          cnt_clr = 1'b1;
          shift_d = '0;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      par_out_q    <= '0;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      par_out_q    <= par_out_d;
      word_valid_q <= word_valid_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign PAR_OUT    = par_out_q;
  assign WORD_VALID = word_valid_q;
  assign BUSY       = busy_q;
  assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// tb_serial_word_loader
// Drives the same serial stream into an MSB-first and an LSB-first loader
// and compares every cycle against words computed from the transmitted bit
// sequence. Define SERIAL_PARITY_CHECK_EN to exercise the parity build.
module tb_serial_word_loader;

  localparam int W = 8;
`ifdef SERIAL_PARITY_CHECK_EN
  localparam int NBITS = W + 1;
`else
  localparam int NBITS = W;
`endif

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         START;
  logic         SVALID;
  logic         SIN;
  logic [W-1:0] par_m, par_l;
  logic         wv_m, wv_l, busy_m, busy_l, ferr_m, ferr_l;

  int checks = 0;
  int errors = 0;

  // Expected bus contents: last successfully loaded word for each bit order.
  logic [W-1:0] exp_m = '0;
  logic [W-1:0] exp_l = '0;

  always #5 CLK = ~CLK;

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .SVALID     (SVALID),
    .SIN        (SIN),
    .PAR_OUT    (par_m),
    .WORD_VALID (wv_m),
    .BUSY       (busy_m),
    .FRAME_ERR  (ferr_m)
  );

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .SVALID     (SVALID),
    .SIN        (SIN),
    .PAR_OUT    (par_l),
    .WORD_VALID (wv_l),
    .BUSY       (busy_l),
    .FRAME_ERR  (ferr_l)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no end, expected finish");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkAll(input string ctx, input logic busy, input logic wv, input logic ferr);
    checkOutput({ctx, " PAR_OUT msb"},    par_m,       exp_m);
    checkOutput({ctx, " PAR_OUT lsb"},    par_l,       exp_l);
    checkOutput({ctx, " BUSY msb"},       W'(busy_m),  W'(busy));
    checkOutput({ctx, " BUSY lsb"},       W'(busy_l),  W'(busy));
    checkOutput({ctx, " WORD_VALID msb"}, W'(wv_m),    W'(wv));
    checkOutput({ctx, " WORD_VALID lsb"}, W'(wv_l),    W'(wv));
    checkOutput({ctx, " FRAME_ERR msb"},  W'(ferr_m),  W'(ferr));
    checkOutput({ctx, " FRAME_ERR lsb"},  W'(ferr_l),  W'(ferr));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic sv, input logic si);
    START  = st;
    SVALID = sv;
    SIN    = si;
    tick();
  endtask

  function automatic logic rndBit();
    return 1'($urandom);
  endfunction

  // One complete frame whose first transmitted bit is word[W-1].
  task automatic sendFrame(input logic [W-1:0] word, input int gmin, input int gmax,
                           input logic start_sv, input logic exp_ferr,
                           input bit b2b, input bit bad_par);
    logic [W:0]   seq;
    logic [W-1:0] new_l;
    bit           good;
    int           gaps;
    for (int i = 0; i < W; i++) seq[i] = word[W-1-i];
    seq[W] = (^word) ^ bad_par;
    new_l = '0;
    for (int i = 0; i < W; i++) new_l[i] = seq[i];
`ifdef SERIAL_PARITY_CHECK_EN
    good = !bad_par;
`else
    good = 1'b1;
`endif
    applyStimulus(1'b1, start_sv, rndBit());
    checkAll("start", 1'b1, 1'b0, exp_ferr);
    for (int i = 0; i < NBITS; i++) begin
      gaps = $urandom_range(gmax, gmin);
      for (int g = 0; g < gaps; g++) begin
        applyStimulus(1'b0, 1'b0, rndBit());
        checkAll("gap", 1'b1, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, seq[i]);
      if (i < NBITS - 1) begin
        checkAll("bit", 1'b1, 1'b0, 1'b0);
      end else begin
        if (good) begin
          exp_m = word;
          exp_l = new_l;
        end
        checkAll("load", 1'b0, good, !good);
      end
    end
    START  = 1'b0;
    SVALID = 1'b0;
    if (!b2b) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkAll("after", 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Start a frame from IDLE and deliver n bits without completing it.
  task automatic partialFrame(input int n);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkAll("pstart", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, rndBit());
      checkAll("pbit", 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [W-1:0] w;
    int           k;
    RST_N  = 1'b0;
    START  = 1'b0;
    SVALID = 1'b0;
    SIN    = 1'b0;
    tick();
    tick();
    checkAll("por", 1'b0, 1'b0, 1'b0);
    RST_N = 1'b1;

    // SVALID alone is ignored in IDLE.
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkAll("idle sv", 1'b0, 1'b0, 1'b0);

    // Continuous frame, then the same frame with 3-cycle gaps.
    sendFrame(8'hD0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    sendFrame(8'hD0, 3, 3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load A0 (LSB-first view 05), abort after 4 bits, then load 81.
    sendFrame(8'hA0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    partialFrame(4);
    sendFrame(8'h81, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0);

    // START with no bits yet taken is a plain restart.
    partialFrame(0);
    sendFrame(8'h3C, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // START in the LOAD cycle begins the next frame directly.
    sendFrame(8'h5A, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    sendFrame(8'hC3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-frame clears everything, then a full frame loads.
    partialFrame(5);
    RST_N = 1'b0;
    START = 1'b0;
    SVALID = 1'b1;
    tick();
    exp_m = '0;
    exp_l = '0;
    checkAll("mid reset", 1'b0, 1'b0, 1'b0);
    RST_N = 1'b1;
    SVALID = 1'b0;
    sendFrame(8'hE7, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized frames, some preceded by an aborted partial frame.
    for (int r = 0; r < 12; r++) begin
      w = W'($urandom);
      if ($urandom_range(3, 0) == 0) begin
        k = $urandom_range(NBITS - 1, 1);
        partialFrame(k);
        sendFrame(w, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0);
      end else begin
        sendFrame(w, 0, 2, rndBit(), 1'b0, 1'b0, 1'b0);
      end
    end

`ifdef SERIAL_PARITY_CHECK_EN
    sendFrame(8'h3C, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    sendFrame(8'hD0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    sendFrame(8'h3C, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    sendFrame(8'hD0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
